control_seq: RTL and testbench

Parametrised instruction sequencer for the SM83 core; generation two of the CPU control FSM. Fetches opcodes through the program counter, decodes NOP, HALT, LD r,d8, LD r,r' and JP a16, and strobes PC, register-file and memory enables. Adds a memory ready handshake with wait-state timeout, and a per-register one-hot enable vector in place of per-register ports. Sits between the PC, register file, memory interface and shared 8-bit data bus.

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/control_seq_if.sv | 32 +++
 rtl/control_decode.sv | 32 +++
 rtl/control_seq.sv | 172 +++++++++++++++++
 tb/tb_control_seq.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared SM83 control constants, state encoding and register-field mapping
package cpu_pkg;

   // Register file indices; F (index 1) is never the target of an opcode field.
   localparam int REG_A = 0;
   localparam int REG_B = 2;
   localparam int REG_C = 3;
   localparam int REG_D = 4;
   localparam int REG_E = 5;
   localparam int REG_H = 6;
   localparam int REG_L = 7;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_HALT  = 8'h76;
   localparam logic [7:0] OP_JP    = 8'hC3;
   localparam logic [2:0] FIELD_HL = 3'd6;

   typedef enum logic [3:0] {
      ST_RST_PC,
      ST_FETCH,
      ST_DECODE,
      ST_INC,
      ST_IMM,
      ST_MOV,
      ST_JP_LO,
      ST_JP_HI,
      ST_JP_LD,
      ST_HALT
   } state_t;

   typedef enum logic [2:0] {
      CLS_NOP,
      CLS_LDI,
      CLS_MOV,
      CLS_JP,
      CLS_HALT,
      CLS_ILLEGAL
   } op_class_t;

   function automatic logic [2:0] field_to_index(input logic [2:0] field);
      case (field)
         3'd0:    return 3'(REG_B);
         3'd1:    return 3'(REG_C);
         3'd2:    return 3'(REG_D);
         3'd3:    return 3'(REG_E);
         3'd4:    return 3'(REG_H);
         3'd5:    return 3'(REG_L);
         3'd7:    return 3'(REG_A);
         default: return 3'(REG_A);
      endcase
   endfunction

endpackage

// File: rtl/control_seq_if.sv
// rtl/control_seq_if.sv - sequencer bundle: memory handshake, PC strobes, register enables, status
interface control_seq_if #(
   parameter int NUM_REGS = 8
);
   logic [7:0]          data_bus;
   logic                mem_rdy;
   logic [15:0]         addr_out;
   logic                addr_oe;
   logic                pc_oe;
   logic                pc_wr;
   logic                pc_inc_en;
   logic                mem_cs;
   logic                mem_oe;
   logic [NUM_REGS-1:0] reg_wr;
   logic [NUM_REGS-1:0] reg_oe;
   logic [7:0]          opcode_q;
   logic                illegal;
   logic                halted;
   logic                bus_err;

   modport master (
      input  data_bus, mem_rdy,
      output addr_out, addr_oe, pc_oe, pc_wr, pc_inc_en, mem_cs, mem_oe,
      output reg_wr, reg_oe, opcode_q, illegal, halted, bus_err
   );

   modport slave (
      output data_bus, mem_rdy,
      input  addr_out, addr_oe, pc_oe, pc_wr, pc_inc_en, mem_cs, mem_oe,
      input  reg_wr, reg_oe, opcode_q, illegal, halted, bus_err
   );
endinterface

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational opcode classifier yielding class and register indices
module control_decode
   import cpu_pkg::*;
(
   input  logic [7:0] opcode,
   output op_class_t  op_class,
   output logic [2:0] dst,
   output logic [2:0] src
);
   logic [2:0] f_dst;
   logic [2:0] f_src;

   assign f_dst = opcode[5:3];
   assign f_src = opcode[2:0];

   always_comb begin
      op_class = CLS_ILLEGAL;
      dst      = field_to_index(f_dst);
      src      = field_to_index(f_src);
      if (opcode == OP_NOP) begin
         op_class = CLS_NOP;
      end else if (opcode == OP_HALT) begin
         op_class = CLS_HALT;
      end else if (opcode == OP_JP) begin
         op_class = CLS_JP;
      end else if (opcode[7:6] == 2'b00 && f_src == FIELD_HL && f_dst != FIELD_HL) begin
         op_class = CLS_LDI;
      end else if (opcode[7:6] == 2'b01 && f_src != FIELD_HL && f_dst != FIELD_HL) begin
         op_class = CLS_MOV;
      end
   end
endmodule

// File: rtl/control_seq.sv
// rtl/control_seq.sv - SM83 instruction sequencer: fetch/decode FSM with memory wait timeout
module control_seq
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_VEC = 16'h0000,
   parameter int          NUM_REGS  = 8,
   parameter int          MAX_WAIT  = 15
) (
   input  logic          clk,
   input  logic          rst,
   control_seq_if.master bus
);
   localparam int              WAIT_W     = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

   if (NUM_REGS < 8) begin : g_bad_num_regs
      $error("control_seq: NUM_REGS must be at least 8");
   end

   state_t            state;
   state_t            state_nxt;
   state_t            ret_state;
   state_t            ret_nxt;
   logic [7:0]        opcode_q;
   logic [7:0]        lo_q;
   logic [7:0]        hi_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic              bus_err_q;
   logic              rd_state;
   logic              timeout;
   op_class_t         op_class;
   logic [2:0]        dst;
   logic [2:0]        src;

   control_decode u_decode (
      .opcode   (opcode_q),
      .op_class (op_class),
      .dst      (dst),
      .src      (src)
   );

   assign rd_state = (state == ST_FETCH) || (state == ST_IMM) ||
                     (state == ST_JP_LO) || (state == ST_JP_HI);
   // Data arriving on the limit cycle still wins over the timeout.
   assign timeout  = rd_state && !bus.mem_rdy && (MAX_WAIT != 0) && (wait_cnt == WAIT_LIMIT);

   always_comb begin
      state_nxt = state;
      ret_nxt   = ret_state;
      case (state)
         ST_RST_PC: state_nxt = ST_FETCH;
         ST_FETCH: begin
            if (bus.mem_rdy)  state_nxt = ST_DECODE;
            else if (timeout) state_nxt = ST_HALT;
         end
         ST_DECODE: begin
            case (op_class)
               CLS_LDI:  begin state_nxt = ST_INC; ret_nxt = ST_IMM;   end
               CLS_MOV:  state_nxt = ST_MOV;
               CLS_JP:   begin state_nxt = ST_INC; ret_nxt = ST_JP_LO; end
               CLS_HALT: state_nxt = ST_HALT;
               default:  begin state_nxt = ST_INC; ret_nxt = ST_FETCH; end
            endcase
         end
         ST_INC: state_nxt = ret_state;
         ST_IMM: begin
            if (bus.mem_rdy) begin
               state_nxt = ST_INC;
               ret_nxt   = ST_FETCH;
            end else if (timeout) begin
               state_nxt = ST_HALT;
            end
         end
         ST_MOV: begin
            state_nxt = ST_INC;
            ret_nxt   = ST_FETCH;
         end
         ST_JP_LO: begin
            if (bus.mem_rdy) begin
               state_nxt = ST_INC;
               ret_nxt   = ST_JP_HI;
            end else if (timeout) begin
               state_nxt = ST_HALT;
            end
         end
         ST_JP_HI: begin
            if (bus.mem_rdy)  state_nxt = ST_JP_LD;
            else if (timeout) state_nxt = ST_HALT;
         end
         ST_JP_LD: state_nxt = ST_FETCH;
         ST_HALT:  state_nxt = ST_HALT;
         default:  state_nxt = ST_RST_PC;
      endcase
   end

   // Outputs come from registered state only, except the IMM write which follows mem_rdy.
   always_comb begin
      bus.addr_out  = '0;
      bus.addr_oe   = 1'b0;
      bus.pc_oe     = 1'b0;
      bus.pc_wr     = 1'b0;
      bus.pc_inc_en = 1'b0;
      bus.mem_cs    = 1'b0;
      bus.mem_oe    = 1'b0;
      bus.reg_wr    = '0;
      bus.reg_oe    = '0;
      bus.illegal   = 1'b0;
      bus.halted    = 1'b0;
      if (!rst) begin
         if (rd_state) begin
            bus.pc_oe  = 1'b1;
            bus.mem_cs = 1'b1;
            bus.mem_oe = 1'b1;
         end
         case (state)
            ST_RST_PC: begin
               bus.addr_out = RESET_VEC;
               bus.addr_oe  = 1'b1;
               bus.pc_wr    = 1'b1;
            end
            ST_DECODE: bus.illegal   = (op_class == CLS_ILLEGAL);
            ST_INC:    bus.pc_inc_en = 1'b1;
            ST_IMM:    bus.reg_wr    = NUM_REGS'(bus.mem_rdy) << dst;
            ST_MOV: begin
               bus.reg_oe = NUM_REGS'(1) << src;
               bus.reg_wr = NUM_REGS'(1) << dst;
            end
            ST_JP_LD: begin
               bus.addr_out = {hi_q, lo_q};
               bus.addr_oe  = 1'b1;
               bus.pc_wr    = 1'b1;
            end
            ST_HALT:  bus.halted = 1'b1;
            default:  ;
         endcase
      end
   end

   assign bus.opcode_q = opcode_q;
   assign bus.bus_err  = bus_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_RST_PC;
         ret_state <= ST_RST_PC;
         opcode_q  <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
         wait_cnt  <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         ret_state <= ret_nxt;
         if (state_nxt != state) begin
            wait_cnt <= '0;
         end else if (rd_state) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (bus.mem_rdy) begin
            case (state)
               ST_FETCH: opcode_q <= bus.data_bus;
               ST_JP_LO: lo_q     <= bus.data_bus;
               ST_JP_HI: hi_q     <= bus.data_bus;
               default:  ;
            endcase
         end
         if (timeout) begin
            bus_err_q <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_control_seq.sv
// tb/tb_control_seq.sv - randomized instruction-level check of control_seq against an ISA reference model
module tb_control_seq;
   localparam logic [15:0] RESET_VEC = 16'h0100;
   localparam int          NUM_REGS  = 8;
   localparam int          MAX_WAIT  = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   control_seq_if #(.NUM_REGS(NUM_REGS)) bus ();

   control_seq #(
      .RESET_VEC (RESET_VEC),
      .NUM_REGS  (NUM_REGS),
      .MAX_WAIT  (MAX_WAIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Environment: memory, program counter and register file respond to the DUT strobes.
   logic [7:0]  mem  [0:65535];
   logic [7:0]  regs [0:NUM_REGS-1];
   logic [15:0] pc;
   logic [7:0]  db;

   // Reference model state and field-to-register map (-1 marks (HL)).
   logic [7:0]  ref_regs [0:NUM_REGS-1];
   logic [15:0] ref_pc;
   int          fmap [8] = '{2, 3, 4, 5, 6, 7, -1, 0};

   int n_vec = 0, n_err = 0;
   int cyc, waits, incs, wrs, pcws, ills, wr_idx;
   int oe_viol = 0, consec_low = 0, force_low = 0;
   bit rand_waits = 0;
   logic [7:0]          wr_val;
   logic [15:0]         pcw_addr;
   logic [NUM_REGS-1:0] oe_at_wr;
   string cur;

   function automatic logic [7:0] reg_init(input int i);
      return 8'(17 * i + 3);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= reg_init(i);
      end else begin
         if (bus.pc_wr)          pc <= bus.addr_out;
         else if (bus.pc_inc_en) pc <= pc + 16'd1;
         for (int i = 0; i < NUM_REGS; i++)
            if (bus.reg_wr[i]) regs[i] <= bus.data_bus;
      end
   end

   always_comb begin
      db = 8'h00;
      if (bus.mem_oe) db = mem[pc];
      else for (int i = 0; i < NUM_REGS; i++) if (bus.reg_oe[i]) db = regs[i];
   end
   assign bus.data_bus = db;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: drive mem_rdy at the falling edge, then sample the settled outputs.
   task automatic step();
      @(negedge clk);
      if (bus.mem_oe && force_low > 0) begin
         bus.mem_rdy = 1'b0;
         force_low--;
      end else if (bus.mem_oe && rand_waits && consec_low < 3 && $urandom_range(0, 3) == 0) begin
         bus.mem_rdy = 1'b0;
      end else begin
         bus.mem_rdy = bus.mem_oe ? 1'b1 : 1'($urandom_range(0, 1));
      end
      consec_low = (bus.mem_oe && !bus.mem_rdy) ? consec_low + 1 : 0;
      #1;
      cyc++;
      if (bus.mem_oe && !bus.mem_rdy) waits++;
      if (bus.pc_inc_en) incs++;
      if (bus.pc_wr) begin pcws++; pcw_addr = bus.addr_out; end
      if (bus.illegal) ills++;
      if (bus.addr_oe && bus.pc_oe) oe_viol++;
      if (bus.reg_wr != '0) begin
         wrs += $countones(bus.reg_wr);
         for (int i = 0; i < NUM_REGS; i++) if (bus.reg_wr[i]) wr_idx = i;
         wr_val   = bus.data_bus;
         oe_at_wr = bus.reg_oe;
      end
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      bus.mem_rdy = 1'b1;
      force_low = 0;
      consec_low = 0;
      repeat (2) @(negedge clk);
      #1;
      check_eq({tag, "_rst_out"}, 32'({bus.addr_oe, bus.pc_wr, bus.pc_oe, bus.pc_inc_en, bus.mem_cs,
               bus.mem_oe, bus.illegal, bus.halted, bus.bus_err, |bus.reg_wr, |bus.reg_oe}), 32'd0);
      check_eq({tag, "_rst_addr"}, 32'(bus.addr_out), 32'd0);
      check_eq({tag, "_rst_opq"}, 32'(bus.opcode_q), 32'd0);
      rst = 1'b0;
      #1;
      check_eq({tag, "_rstpc_addr"}, 32'(bus.addr_out), 32'(RESET_VEC));
      check_eq({tag, "_rstpc_ctl"}, 32'({bus.addr_oe, bus.pc_wr, bus.pc_oe, bus.mem_oe}), 32'b1100);
      for (int i = 0; i < NUM_REGS; i++) ref_regs[i] = reg_init(i);
      ref_pc = RESET_VEC;
      @(posedge clk);
      #1;
      check_eq({tag, "_first_fetch"}, 32'({bus.pc_oe, bus.mem_cs, bus.mem_oe}), 32'b111);
      check_eq({tag, "_pc"}, 32'(pc), 32'(RESET_VEC));
   endtask

   // Execute one non-HALT instruction at ref_pc and compare against the ISA-level expectation.
   task automatic exec_instr(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2);
      int base, e_inc, e_wr, e_idx, e_src, e_pcw, e_ill;
      logic [7:0]  e_val;
      logic [15:0] e_pc;
      logic [2:0]  fd, fs;
      fd = op[5:3];
      fs = op[2:0];
      cur = $sformatf("op%02h@%04h", op, ref_pc);
      mem[ref_pc] = op;
      mem[ref_pc + 16'd1] = b1;
      mem[ref_pc + 16'd2] = b2;
      base = 3; e_inc = 1; e_wr = 0; e_idx = 0; e_src = -1; e_pcw = 0; e_ill = 0;
      e_val = 8'h00;
      e_pc = ref_pc + 16'd1;
      if (op == 8'h00) begin
      end else if (op == 8'hC3) begin
         base = 7; e_inc = 2; e_pcw = 1; e_pc = {b2, b1};
      end else if (op < 8'h40 && fs == 3'd6 && fd != 3'd6) begin
         base = 5; e_inc = 2; e_wr = 1; e_idx = fmap[fd]; e_val = b1; e_pc = ref_pc + 16'd2;
      end else if (op >= 8'h40 && op < 8'h80 && fs != 3'd6 && fd != 3'd6) begin
         base = 4; e_wr = 1; e_idx = fmap[fd]; e_src = fmap[fs]; e_val = ref_regs[e_src];
      end else begin
         e_ill = 1;
      end
      cyc = 0; waits = 0; incs = 0; wrs = 0; pcws = 0; ills = 0;
      wr_idx = -1; wr_val = 8'h00; pcw_addr = 16'h0000; oe_at_wr = '0;
      while (cyc < base + waits && cyc < 200) step();
      check_eq({cur, "_bounded"}, 32'(cyc < 200), 32'd1);
      check_eq({cur, "_inc"}, incs, e_inc);
      check_eq({cur, "_wr_cnt"}, wrs, e_wr);
      check_eq({cur, "_pcw_cnt"}, pcws, e_pcw);
      check_eq({cur, "_illegal"}, ills, e_ill);
      if (e_wr != 0) begin
         check_eq({cur, "_wr_idx"}, wr_idx, e_idx);
         check_eq({cur, "_wr_val"}, 32'(wr_val), 32'(e_val));
         check_eq({cur, "_src_oe"}, 32'(oe_at_wr), (e_src >= 0) ? (32'd1 << e_src) : 32'd0);
      end
      if (e_pcw != 0) check_eq({cur, "_jp_addr"}, 32'(pcw_addr), 32'(e_pc));
      @(posedge clk);
      #1;
      check_eq({cur, "_next_pc"}, 32'(pc), 32'(e_pc));
      check_eq({cur, "_next_fetch"}, 32'({bus.pc_oe, bus.mem_oe}), 32'b11);
      if (e_wr != 0) ref_regs[e_idx] = e_val;
      ref_pc = e_pc;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int first;
      logic [7:0] op;
      logic [7:0] ill_ops [8] = '{8'hD3, 8'h36, 8'h46, 8'h70, 8'hCB, 8'hFF, 8'h01, 8'hDD};
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      bus.mem_rdy = 1'b1;

      do_reset("dir");
      exec_instr(8'h3E, 8'h5A, 8'h00);
      exec_instr(8'h78, 8'h00, 8'h00);
      exec_instr(8'hC3, 8'h34, 8'h12);
      exec_instr(8'hD3, 8'h00, 8'h00);
      exec_instr(8'h36, 8'h00, 8'h00);
      exec_instr(8'h7F, 8'h00, 8'h00);
      force_low = 3;
      exec_instr(8'h00, 8'h00, 8'h00);
      force_low = 3;
      exec_instr(8'h06, 8'hA5, 8'h00);

      do_reset("lim");
      force_low = 15;
      exec_instr(8'h00, 8'h00, 8'h00);
      check_eq("lim_no_err", 32'(bus.bus_err), 32'd0);

      do_reset("tmo");
      force_low = 1000;
      first = 0;
      for (int k = 1; k <= 30 && first == 0; k++) begin
         step();
         if (bus.bus_err) first = k;
      end
      check_eq("tmo_cycle", first, 17);
      check_eq("tmo_state", 32'({bus.halted, bus.bus_err, bus.mem_oe}), 32'b110);
      force_low = 0;

      do_reset("halt");
      mem[RESET_VEC] = 8'h76;
      repeat (2) step();
      for (int k = 0; k < 5; k++) begin
         step();
         check_eq("halt_hold", 32'({bus.halted, bus.mem_oe, bus.pc_inc_en, bus.pc_wr, bus.addr_oe}), 32'b10000);
      end

      do_reset("jpmid");
      mem[RESET_VEC] = 8'hC3;
      mem[RESET_VEC + 16'd1] = 8'h34;
      mem[RESET_VEC + 16'd2] = 8'h12;
      repeat (6) step();
      check_eq("jpmid_in_jphi", 32'({bus.pc_oe, bus.mem_oe, bus.pc_wr}), 32'b110);
      mem[RESET_VEC] = 8'h00;
      do_reset("jpmid2");
      exec_instr(8'h00, 8'h00, 8'h00);

      do_reset("rnd");
      rand_waits = 1;
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 5))
            0: exec_instr(8'h00, 8'h00, 8'h00);
            1: begin
               int f;
               f = $urandom_range(0, 6);
               if (f == 6) f = 7;
               exec_instr({2'b00, 3'(f), 3'b110}, 8'($urandom), 8'h00);
            end
            2: begin
               int d, s;
               d = $urandom_range(0, 6);
               if (d == 6) d = 7;
               s = $urandom_range(0, 6);
               if (s == 6) s = 7;
               exec_instr({2'b01, 3'(d), 3'(s)}, 8'h00, 8'h00);
            end
            3: exec_instr(8'hC3, 8'($urandom), 8'($urandom_range(1, 239)));
            4: exec_instr(ill_ops[$urandom_range(0, 7)], 8'h00, 8'h00);
            default: begin
               op = 8'($urandom);
               if (op == 8'h76 || op == 8'hC3) op = 8'h00;
               exec_instr(op, 8'($urandom), 8'h00);
            end
         endcase
      end
      for (int i = 0; i < NUM_REGS; i++)
         check_eq($sformatf("rnd_reg%0d", i), 32'(regs[i]), 32'(ref_regs[i]));
      check_eq("oe_exclusive", oe_viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
